stream_dwc_down: RTL
====================

# stream_dwc_down

Registered AXI-Stream width down-converter that sits directly downstream of a 24-bit streaming FIFO in the dataflow pipeline. Each wide input word is split into narrower output beats, least-significant slice first. The next layer consumes a narrower stream at full rate. Throughput is one input word per R output beats with no bubbles, where R = IN_WIDTH/OUT_WIDTH.

## Interface
- IN_WIDTH, 24, input word width in bits.
- OUT_WIDTH, 8, output beat width in bits. Must divide IN_WIDTH.
- R (localparam), IN_WIDTH/OUT_WIDTH, beats per input word. R ≥ 1.
- CW (localparam), max(1, clog2(R)), beat-counter width.

Ports:
- ap_clk  in  1  clock. All logic is on the rising edge.
- ap_rst  in  1  reset, asynchronous, active-high.
- in0_V_V_TDATA  in  IN_WIDTH  input word.
- in0_V_V_TVALID  in  1  input valid.
- in0_V_V_TREADY  out  1  input ready.
- out_V_V_TDATA  out  OUT_WIDTH  output beat.
- out_V_V_TVALID  out  1  output valid.
- out_V_V_TREADY  in  1  output ready.
- beat_idx  out  CW  index of the slice currently presented (debug/verification).

## Operation
- Internal state:
  - shift register sr[IN_WIDTH-1:0]
  - beat counter cnt[CW-1:0]
  - state ∈ {EMPTY, HOLD}
- Output mapping:
  - out_V_V_TDATA = sr[OUT_WIDTH-1:0].
  - out_V_V_TVALID = (state==HOLD).
  - beat_idx = cnt.
- Input ready: in0_V_V_TREADY = (state==EMPTY) || (cnt==R-1 && out_V_V_TREADY). It is combinational from out_V_V_TREADY; no combinational path from TVALID to TREADY.
- Handshake events:
  - in_fire = in0_V_V_TVALID && in0_V_V_TREADY
  - out_fire = out_V_V_TVALID && out_V_V_TREADY
- Transitions:
  - EMPTY, in_fire → HOLD; sr ← in0_V_V_TDATA; cnt ← 0.
  - EMPTY, no in_fire → stay EMPTY.
  - HOLD, out_fire, cnt<R-1 → sr ← sr >> OUT_WIDTH (zero-fill); cnt ← cnt+1.
  - HOLD, out_fire, cnt==R-1, in_fire → stay HOLD; sr ← new word; cnt ← 0. This is back-to-back with no bubble.
  - HOLD, out_fire, cnt==R-1, no in_fire → EMPTY; cnt ← 0.
  - HOLD, no out_fire → hold sr, cnt and out_V_V_TDATA stable (AXI rule).
- R==1: the block degenerates to a one-deep registered pipeline stage with the same rules.
- No data reordering, no drops, no duplication.

## Timing
- Reset (async assert, sync release via the clock edge): state=EMPTY, cnt=0, sr=0. Resulting outputs: out_V_V_TVALID=0, out_V_V_TDATA=0, beat_idx=0, in0_V_V_TREADY=1 (the first cycle after release).
- Latency: an input accepted at edge N presents slice 0 from edge N onward, i.e. out_V_V_TVALID=1 in the cycle after acceptance.
- Sustained rate with out_V_V_TREADY=1: one beat per cycle, one input accepted every R cycles.
- Backpressure: while out_V_V_TREADY=0 in HOLD, the input is not accepted and the output is frozen.
- Reset mid-word: the remaining slices are discarded. No output valid until the next input is accepted.
- Input TVALID dropping while TREADY=0 is tolerated. The block only samples data on in_fire.

## Structure
- A shared package holds a function for the counter width (clog2 with floor 1). The parameter check for IN_WIDTH % OUT_WIDTH == 0 is an elaboration-time assertion.
- Single module; no sub-module needed. The state enum is local to the module.

## Test plan
- Single word, ready=1: in 0xABCDEF → out 0xEF, 0xCD, 0xAB on three consecutive cycles; beat_idx 0, 1, 2; then TVALID=0.
- Back-to-back: inputs 0x030201, 0x060504 held valid, ready=1 → out 01..06 in six consecutive cycles; in_ready high on cycles 0 and 3 only.
- Backpressure: out_ready=0 for 5 cycles after the first beat of 0x112233 → out stays 0x33 with valid=1 and in_ready=0; on release, 0x22, 0x11 follow.
- Reset mid-word: assert ap_rst after beat 0x33 of 0x112233 → valid drops immediately; after release, input 0xAABBCC yields 0xCC, 0xBB, 0xAA.
- Random valid/ready throttling, 1000 words, scoreboard against a reference slicer → exact sequence match, no TDATA change while valid && !ready.
- R==1 (IN_WIDTH=OUT_WIDTH=24): 0x123456 → out 0x123456 one cycle later; full throughput with ready=1.

Source files
------------

// File: rtl/stream_dwc_down_pkg.sv
// -----------------------------------------------------------------------------
// stream_dwc_down_pkg
//   Shared definitions for the stream width down-converter.
//   Contents:
//     cw_of(r) - width of a counter that indexes r beats (clog2 with floor 1)
// -----------------------------------------------------------------------------
package stream_dwc_down_pkg;

  // A one-beat converter still needs a 1-bit counter so that every port and
  // register keeps a legal, non-zero width.
  function automatic int cw_of(input int r);
    return (r <= 1) ? 1 : $clog2(r);
  endfunction

endpackage : stream_dwc_down_pkg

// File: rtl/stream_dwc_down_if.sv
// -----------------------------------------------------------------------------
// stream_dwc_down_if
//   Bundles the wide input stream, the narrow output stream and the debug beat
//   index of the width down-converter. Signal names follow the HLS-style
//   AXI-Stream naming used by the surrounding dataflow pipeline.
//   Modports:
//     slave  - converter side: consumes in0_*, produces out_* and beat_idx
//     master - environment side: produces in0_*, consumes out_* and beat_idx
//   Parameters must match those of the converter instance that uses it.
// -----------------------------------------------------------------------------
interface stream_dwc_down_if
  import stream_dwc_down_pkg::*;
#(
  parameter int IN_WIDTH  = 24,
  parameter int OUT_WIDTH = 8
) ();

  localparam int CW = cw_of(IN_WIDTH / OUT_WIDTH);

  logic [IN_WIDTH-1:0]  in0_V_V_TDATA;
  logic                 in0_V_V_TVALID;
  logic                 in0_V_V_TREADY;
  logic [OUT_WIDTH-1:0] out_V_V_TDATA;
  logic                 out_V_V_TVALID;
  logic                 out_V_V_TREADY;
  logic [CW-1:0]        beat_idx;

  modport slave (
    input  in0_V_V_TDATA, in0_V_V_TVALID, out_V_V_TREADY,
    output in0_V_V_TREADY, out_V_V_TDATA, out_V_V_TVALID, beat_idx
  );

  modport master (
    output in0_V_V_TDATA, in0_V_V_TVALID, out_V_V_TREADY,
    input  in0_V_V_TREADY, out_V_V_TDATA, out_V_V_TVALID, beat_idx
  );

endinterface : stream_dwc_down_if

// File: rtl/stream_dwc_down.sv
// -----------------------------------------------------------------------------
// stream_dwc_down
//   Registered AXI-Stream width down-converter. Each IN_WIDTH-bit input word is
//   emitted as R = IN_WIDTH/OUT_WIDTH output beats, least-significant slice
//   first. A new word is accepted in the same cycle the last beat of the
//   previous one leaves, so sustained throughput is one word per R cycles.
//   Ports:
//     ap_clk  - clock, rising edge
//     ap_rst  - asynchronous active-high reset
//     s       - stream_dwc_down_if.slave:
//                 in0_V_V_TDATA/TVALID/TREADY  wide input stream
//                 out_V_V_TDATA/TVALID/TREADY  narrow output stream
//                 beat_idx                     index of the slice on out_V_V_TDATA
// -----------------------------------------------------------------------------
module stream_dwc_down
  import stream_dwc_down_pkg::*;
#(
  parameter int IN_WIDTH  = 24,
  parameter int OUT_WIDTH = 8
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  stream_dwc_down_if.slave  s
);

  localparam int            R    = IN_WIDTH / OUT_WIDTH;
  localparam int            CW   = cw_of(R);
  localparam logic [CW-1:0] LAST = CW'(R - 1);

  if (OUT_WIDTH < 1 || (IN_WIDTH % OUT_WIDTH) != 0) begin : g_width_check
    $fatal(1, "stream_dwc_down: OUT_WIDTH must divide IN_WIDTH");
  end

  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [IN_WIDTH-1:0] sr_q,    sr_d;
  logic [CW-1:0]       cnt_q,   cnt_d;

  logic in_ready;
  logic in_fire;
  logic out_fire;
  logic last_beat;

  // Ready depends only on state and downstream ready, never on in0 TVALID,
  // so no combinational loop can form through an upstream that waits on ready.
  assign last_beat = (cnt_q == LAST);
  assign in_ready  = (state_q == EMPTY) || (last_beat && s.out_V_V_TREADY);
  assign in_fire   = s.in0_V_V_TVALID && in_ready;
  assign out_fire  = (state_q == HOLD) && s.out_V_V_TREADY;

  assign s.in0_V_V_TREADY = in_ready;
  assign s.out_V_V_TDATA  = sr_q[OUT_WIDTH-1:0];
  assign s.out_V_V_TVALID = (state_q == HOLD);
  assign s.beat_idx       = cnt_q;

  always_comb begin
    // NOTE: every next-state signal is given its hold value first, so any path
    // through the case below that does not assign it cannot infer a latch.
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d = HOLD;
          sr_d    = s.in0_V_V_TDATA;
          cnt_d   = '0;
        end
      end

      HOLD: begin
        if (out_fire) begin
          if (!last_beat) begin
            // Next slice slides down into the output window; zero-fill on top.
            sr_d  = sr_q >> OUT_WIDTH;
            cnt_d = cnt_q + CW'(1);
          end else if (in_fire) begin
            // Last beat leaves as the next word arrives: no bubble.
            sr_d  = s.in0_V_V_TDATA;
            cnt_d = '0;
          end else begin
            state_d = EMPTY;
            cnt_d   = '0;
          end
        end
      end

      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q <= EMPTY;
      sr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples
      // the pre-edge values of the others, independent of statement order.
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule : stream_dwc_down
